// File: rtl/if_fetch_pkg.sv
// Shared MIPS pipeline constants used by the fetch stage and the IF/ID register.
// Holds the NOP encoding presented as a bubble, the PC width, the reset fetch
// address and the sequential PC increment.
package if_fetch_pkg;

  // Byte-addressed, word-aligned program counter width.
  localparam int MIPS_PC_W = 9;

  // First fetch address after reset.
  localparam logic [MIPS_PC_W-1:0] MIPS_RESET_PC = 9'h000;

  // Bubble instruction presented whenever no real fetch is buffered
  // (add $0,$0,$0).
  localparam logic [31:0] MIPS_NOP = 32'h0000_0020;

  // Sequential fetch step: one 32-bit word.
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests, buffers one instruction for IF/ID.
// Latency: output valid the cycle after imem_rvalid (registered); 1-cycle memory gives one instruction per 2 cycles.
// Backpressure: stall holds the buffered instruction and blocks new requests; redirect flushes buffer and in-flight fetch.
//
// Ports:
//   clk, rst_n               pipeline clock, asynchronous active-low reset
//   stall                    hazard-unit stall (same signal that holds IF/ID)
//   redirect, redirect_pc    taken branch / jump from ID and its target (low 2 bits ignored)
//   imem_req, imem_addr      one-cycle request strobe and word address
//   imem_rvalid, imem_rdata  response strobe and instruction, >=1 cycle after the request
//   IF_pc_4, IF_inst         PC+4 and instruction presented to IF/ID (0 / NOP when empty)
//   IF_valid                 presented instruction is real, not a bubble
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              PC_W     = MIPS_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(MIPS_RESET_PC),
  parameter logic [31:0]     NOP      = MIPS_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] IF_pc_4,
  output logic [31:0]     IF_inst,
  output logic            IF_valid
);

  // State registers.
  logic [PC_W-1:0] pc;           // next address to fetch
  logic [PC_W-1:0] req_pc_4;     // PC+4 of the request in flight
  logic            outstanding;  // a request has been issued and not yet answered
  logic            kill;         // the in-flight response belongs to a flushed path
  logic            out_valid;    // out_inst/out_pc_4 hold a real instruction
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc_4;
  logic            run;          // first edge after reset release has passed

  logic            consume;
  logic            resp_hit;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_tgt;

  // IF/ID takes the buffered instruction at this edge.
  assign consume  = out_valid & ~stall & ~redirect;

  // Responses only count while a request is actually in flight; stray
  // strobes (e.g. from a request issued before a reset) are ignored.
  assign resp_hit = imem_rvalid & outstanding;

  // Modulo 2^PC_W: the top word wraps back to address zero.
  assign pc_inc   = pc + PC_INC[PC_W-1:0];

  // Force word alignment of the redirect target.
  assign redirect_tgt = redirect_pc & ~PC_W'(3);

  // Issue only when nothing is in flight and the buffer will be free at this
  // edge, so a response can always be captured without a second buffer.
  assign imem_req  = run & ~outstanding & ~kill & ~redirect & (~out_valid | consume);
  assign imem_addr = pc;

  // Outputs come straight from registers; no path from imem_rdata.
  assign IF_valid = out_valid;
  assign IF_inst  = out_valid ? out_inst : NOP;
  assign IF_pc_4  = out_valid ? out_pc_4 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc_4    <= '0;
      outstanding <= 1'b0;
      kill        <= 1'b0;
      out_valid   <= 1'b0;
      out_inst    <= NOP;
      out_pc_4    <= '0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;

      if (redirect) begin
        // Redirect wins over stall, response and issue.
        pc        <= redirect_tgt;
        out_valid <= 1'b0;
        if (outstanding) begin
          if (imem_rvalid) begin
            // The stale response lands this very cycle: drop it now.
            outstanding <= 1'b0;
            kill        <= 1'b0;
          end else begin
            // Still in flight: remember to discard it when it arrives.
            kill <= 1'b1;
          end
        end
      end else begin
        if (resp_hit) begin
          outstanding <= 1'b0;
          if (kill) begin
            kill <= 1'b0;
          end else begin
            // Buffer is known free here: issue required it free or consumed.
            out_inst  <= imem_rdata;
            out_pc_4  <= req_pc_4;
            out_valid <= 1'b1;
          end
        end else if (consume) begin
          out_valid <= 1'b0;
        end

        // imem_req requires ~outstanding, so it never coincides with resp_hit.
        if (imem_req) begin
          outstanding <= 1'b1;
          req_pc_4    <= pc_inc;
          pc          <= pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = 9'h000;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [8:0]  IF_pc_4;
  logic [31:0] IF_inst;
  logic        IF_valid;

  int tests = 0;
  int failed = 0;

  // Memory model state.
  int         mem_lat = 1;
  int         mem_cnt = 0;
  logic [8:0] mem_tag = 9'h000;
  logic       smp_req;
  logic [8:0] smp_addr;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .IF_pc_4     (IF_pc_4),
    .IF_inst     (IF_inst),
    .IF_valid    (IF_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: response strobe mem_lat cycles after the request,
  // data tagged with the request address. Not reset, so it can produce
  // stray responses across a DUT reset.
  always begin
    @(posedge clk);
    smp_req  = imem_req;
    smp_addr = imem_addr;
    #1;
    if (smp_req) begin
      mem_cnt = mem_lat;
      mem_tag = smp_addr;
    end else if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
    end
    imem_rvalid = (mem_cnt == 1);
    imem_rdata  = imem_rvalid ? (32'hA000_0000 | {23'd0, mem_tag}) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rst_req: got %b want 0", imem_req); end
    tests++; if (imem_addr !== 9'h000) begin failed++; $display("FAIL rst_addr: got %h want 000", imem_addr); end
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b want 0", IF_valid); end
    tests++; if (IF_pc_4 !== 9'h000) begin failed++; $display("FAIL rst_pc4: got %h want 000", IF_pc_4); end
    tests++; if (IF_inst !== 32'h0000_0020) begin failed++; $display("FAIL rst_inst: got %h want 00000020", IF_inst); end
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rst_norun_req: got %b want 0", imem_req); end
    tick();
  endtask

  task automatic test_basic();
    tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL basic_req0: got %b want 1", imem_req); end
    tests++; if (imem_addr !== 9'h000) begin failed++; $display("FAIL basic_addr0: got %h want 000", imem_addr); end
    tick();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL basic_busy: got %b want 0", imem_req); end
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL basic_v0: got %b want 0", IF_valid); end
    tick();
    tests++; if (IF_valid !== 1'b1) begin failed++; $display("FAIL basic_v1: got %b want 1", IF_valid); end
    tests++; if (IF_inst !== 32'hA000_0000) begin failed++; $display("FAIL basic_inst0: got %h want a0000000", IF_inst); end
    tests++; if (IF_pc_4 !== 9'h004) begin failed++; $display("FAIL basic_pc4_0: got %h want 004", IF_pc_4); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h004) begin failed++; $display("FAIL basic_addr4: got req %b addr %h want 1 004", imem_req, imem_addr); end
    tick();
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL basic_v2: got %b want 0", IF_valid); end
    tick();
    tests++; if (IF_valid !== 1'b1) begin failed++; $display("FAIL basic_v3: got %b want 1", IF_valid); end
    tests++; if (IF_inst !== 32'hA000_0004) begin failed++; $display("FAIL basic_inst1: got %h want a0000004", IF_inst); end
    tests++; if (IF_pc_4 !== 9'h008) begin failed++; $display("FAIL basic_pc4_1: got %h want 008", IF_pc_4); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h008) begin failed++; $display("FAIL basic_addr8: got req %b addr %h want 1 008", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    redirect = 1'b1;
    redirect_pc = 9'h010;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL stall_redir_noreq: got %b want 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h010) begin failed++; $display("FAIL stall_addr10: got req %b addr %h want 1 010", imem_req, imem_addr); end
    tick();
    stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (IF_valid !== 1'b1 || IF_inst !== 32'hA000_0010 || IF_pc_4 !== 9'h014 || imem_req !== 1'b0) begin
        failed++;
        $display("FAIL stall_hold[%0d]: got v %b inst %h pc4 %h req %b want 1 a0000010 014 0", i, IF_valid, IF_inst, IF_pc_4, imem_req);
      end
      if (i < 3) tick();
    end
    stall = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h014) begin failed++; $display("FAIL stall_release: got req %b addr %h want 1 014", imem_req, imem_addr); end
    tick();
    tick();
    tests++; if (IF_valid !== 1'b1 || IF_pc_4 !== 9'h018) begin failed++; $display("FAIL stall_next: got v %b pc4 %h want 1 018", IF_valid, IF_pc_4); end
  endtask

  task automatic test_kill();
    bit seen;
    mem_lat = 3;
    redirect = 1'b1;
    redirect_pc = 9'h020;
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h020) begin failed++; $display("FAIL kill_addr20: got req %b addr %h want 1 020", imem_req, imem_addr); end
    tick();
    redirect = 1'b1;
    redirect_pc = 9'h0A3;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL kill_redir_noreq: got %b want 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0 || IF_valid !== 1'b0) begin failed++; $display("FAIL kill_wait1: got req %b v %b want 0 0", imem_req, IF_valid); end
    tick();
    tests++; if (imem_req !== 1'b0 || IF_valid !== 1'b0) begin failed++; $display("FAIL kill_wait2: got req %b v %b want 0 0", imem_req, IF_valid); end
    tick();
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL kill_stale_dropped: got %b want 0", IF_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h0A0) begin failed++; $display("FAIL kill_addrA0: got req %b addr %h want 1 0a0", imem_req, imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (IF_valid === 1'b1);
    end
    tests++; if (!seen) begin failed++; $display("FAIL kill_timeout: got no IF_valid within 10 cycles want 1"); end
    tests++; if (IF_pc_4 !== 9'h0A4 || IF_inst !== 32'hA000_00A0) begin failed++; $display("FAIL kill_present: got pc4 %h inst %h want 0a4 a00000a0", IF_pc_4, IF_inst); end
  endtask

  task automatic test_redirect_on_response();
    mem_lat = 1;
    redirect = 1'b1;
    redirect_pc = 9'h00C;
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h00C) begin failed++; $display("FAIL rr_addrC: got req %b addr %h want 1 00c", imem_req, imem_addr); end
    tick();
    redirect = 1'b1;
    redirect_pc = 9'h040;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rr_noreq: got %b want 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL rr_dropped: got %b want 0", IF_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h040) begin failed++; $display("FAIL rr_addr40: got req %b addr %h want 1 040", imem_req, imem_addr); end
    tick();
    tick();
    tests++; if (IF_valid !== 1'b1 || IF_pc_4 !== 9'h044 || IF_inst !== 32'hA000_0040) begin failed++; $display("FAIL rr_present: got v %b pc4 %h inst %h want 1 044 a0000040", IF_valid, IF_pc_4, IF_inst); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 9'h1FC;
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h1FC) begin failed++; $display("FAIL wrap_addr1FC: got req %b addr %h want 1 1fc", imem_req, imem_addr); end
    tick();
    tick();
    tests++; if (IF_valid !== 1'b1 || IF_pc_4 !== 9'h000) begin failed++; $display("FAIL wrap_pc4: got v %b pc4 %h want 1 000", IF_valid, IF_pc_4); end
    tests++; if (IF_inst !== 32'hA000_01FC) begin failed++; $display("FAIL wrap_inst: got %h want a00001fc", IF_inst); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin failed++; $display("FAIL wrap_next: got req %b addr %h want 1 000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    tick();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rm_outstanding: got %b want 0", imem_req); end
    rst_n = 1'b0;
    #1;
    tests++; if (IF_valid !== 1'b0 || IF_pc_4 !== 9'h000 || IF_inst !== 32'h0000_0020) begin failed++; $display("FAIL rm_outputs: got v %b pc4 %h inst %h want 0 000 00000020", IF_valid, IF_pc_4, IF_inst); end
    tests++; if (imem_req !== 1'b0 || imem_addr !== 9'h000) begin failed++; $display("FAIL rm_req: got req %b addr %h want 0 000", imem_req, imem_addr); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rm_norun: got %b want 0", imem_req); end
    tick();
    tests++; if (IF_valid !== 1'b0) begin failed++; $display("FAIL rm_stray_ignored: got %b want 0", IF_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin failed++; $display("FAIL rm_first_req: got req %b addr %h want 1 000", imem_req, imem_addr); end
    tick();
    tests++; if (IF_valid !== 1'b0 || imem_req !== 1'b0) begin failed++; $display("FAIL rm_after: got v %b req %b want 0 0", IF_valid, imem_req); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_kill();
    test_redirect_on_response();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues single-outstanding requests to the instruction memory. It buffers one returned instruction and presents it as IF_pc_4/IF_inst, holding it while the pipeline stalls. On a branch/jump redirect from ID it discards any in-flight or buffered fetch and restarts at the target.

Parameters:
PC_W, 9, PC width in bits (byte address, word aligned).
RESET_PC, 9'h000, first fetch address after reset.
NOP, 32'h0000_0020, instruction presented when no valid fetch is buffered.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard-unit stall; the same signal that holds IF/ID
redirect  in  1  branch taken or jump, resolved in ID
redirect_pc  in  PC_W  target address; bits [1:0] ignored (forced 0)
imem_req  out  1  one-cycle request strobe
imem_addr  out  PC_W  request address, valid with imem_req
imem_rvalid  in  1  response strobe, latency ≥1 cycle after imem_req
imem_rdata  in  32  response instruction, valid with imem_rvalid
IF_pc_4  out  PC_W  fetch address + 4 of the presented instruction
IF_inst  out  32  presented instruction
IF_valid  out  1  presented instruction is real (not a NOP bubble)

Behaviour:
- State registers: pc (next fetch address), req_pc_4, outstanding, kill, out_valid, out_inst, out_pc_4, run.
- Reset (async, rst_n low): pc=RESET_PC, outstanding=0, kill=0, out_valid=0, run=0. Outputs: imem_req=0, imem_addr=RESET_PC, IF_valid=0, IF_pc_4=0, IF_inst=NOP. run goes to 1 on the first clk edge after rst_n rises. No request is issued before that edge.
- consume = out_valid & ~stall & ~redirect. The buffered instruction is taken by IF/ID at this edge.
- Issue rule: imem_req = run & ~outstanding & ~kill & ~redirect & (~out_valid | consume). imem_addr=pc.
- On issue: outstanding←1, req_pc_4←pc+4, pc←pc+4. Arithmetic is modulo 2^PC_W, so 0x1FC wraps to 0x000.
- Response with outstanding=1, kill=0, redirect=0: out_inst←imem_rdata, out_pc_4←req_pc_4, out_valid←1, outstanding←0.
  - The buffer is guaranteed free at this point, because issue required it free or consumed.
- Response with kill=1: data dropped, outstanding←0, kill←0. The next cycle may issue.
- imem_rvalid with outstanding=0: ignored.
- consume without a new response: out_valid←0.
- Redirect has priority over stall, response and issue:
  - pc←{redirect_pc[PC_W-1:2],2'b00} and out_valid←0.
  - If outstanding=1 and imem_rvalid=0, then kill←1.
  - If imem_rvalid=1 in the same cycle, the data is dropped and outstanding←0.
  - No imem_req is issued in the redirect cycle.
- Stall with out_valid=1: outputs are held unchanged and no new request is issued. A stall does not cancel an outstanding request; its response is buffered normally when the buffer is free.
- Outputs: IF_valid=out_valid, IF_inst=out_valid?out_inst:NOP, IF_pc_4=out_valid?out_pc_4:0. These are registered-only paths with no combinational path from imem_rdata.
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- Reset asserted mid-request: all state clears. A response arriving after reset release with outstanding=0 is ignored.

Decomposition:
- Shared MIPS package: NOP (32'h0000_0020), PC_W, RESET_PC, and pc increment constant 4. The IF/ID register uses the same NOP and PC_W.
- No sub-module; the logic is a single register set plus next-state logic.

Test Plan:
- Reset, 1-cycle memory returning addr-tagged data 32'hA000_0000|addr, stall=0 → imem_addr sequence 0x000,0x004,0x008.
  - IF_inst 32'hA000_0000 with IF_pc_4=0x004, then 32'hA000_0004 with IF_pc_4=0x008. IF_valid toggles 1/0 at half rate.
- Buffered inst at pc 0x010, stall=1 for 4 cycles → IF_inst/IF_pc_4 (0x014) stable, imem_req=0 throughout. Next request 0x014 occurs in the cycle stall drops.
- 3-cycle memory: redirect to 0x0A3 one cycle after issuing 0x020 → kill set, stale response dropped (IF_valid stays 0).
  - Next imem_addr=0x0A0. Presented IF_pc_4=0x0A4.
- redirect to 0x040 in the same cycle imem_rvalid returns data for 0x00C → data dropped, IF_valid=0 next cycle, next request addr 0x040.
- redirect to 0x1FC → fetch 0x1FC, IF_pc_4=0x000, next imem_addr=0x000 (wrap).
- Assert rst_n low while a request is outstanding, release, memory then returns stray rvalid → stray response ignored.
  - First request after release is RESET_PC. Outputs read NOP/0/0 during reset.
